// File: rtl/ber_pkg.sv
// Shared types and constants for the BER accumulator.
package ber_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } ber_state_t;

    // Edges needed for the last accepted pair to reach the counters and settle.
    localparam int unsigned BER_DRAIN_CYCLES = 3;

endpackage

// File: rtl/ber_popcount.sv
// Combinational population count built as a balanced adder tree.
// Result width is clog2(DATA_W)+1; the parent registers it.
module ber_popcount
    import ber_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic [DATA_W-1:0]        data,
    output logic [$clog2(DATA_W):0]  count
);

    // Recursive split: each level halves the word and adds the two sub-counts.
    if (DATA_W == 1) begin : g_leaf
        assign count = data;
    end else begin : g_node
        localparam int unsigned HALF = DATA_W / 2;

        logic [$clog2(HALF):0] lo_cnt;
        logic [$clog2(HALF):0] hi_cnt;

        ber_popcount #(.DATA_W(HALF)) u_lo (
            .data  (data[HALF-1:0]),
            .count (lo_cnt)
        );

        ber_popcount #(.DATA_W(HALF)) u_hi (
            .data  (data[DATA_W-1:HALF]),
            .count (hi_cnt)
        );

        assign count = {1'b0, lo_cnt} + {1'b0, hi_cnt};
    end

endmodule

// File: rtl/ber_accumulator.sv
// Bit-error accumulator: XOR/popcount pipeline over tx/rx word pairs, stopping after a programmed bit count.
// Optional BER_ACC_WORD_ERR_EN adds a saturating count of words containing at least one error.
module ber_accumulator
    import ber_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 48
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic [CNT_W-1:0]  target_bits,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_tx_data,
    input  logic [DATA_W-1:0] s_rx_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count,
    output logic [CNT_W-1:0]  err_count,
`ifdef BER_ACC_WORD_ERR_EN
    output logic [CNT_W-1:0]  word_err_count,
`endif
    output logic              overflow
);

    localparam int unsigned    POP_W     = $clog2(DATA_W) + 1;
    localparam logic [CNT_W:0] WORD_BITS = (CNT_W+1)'(DATA_W);

    ber_state_t        state;
    logic [1:0]        drain_cnt;
    logic [CNT_W:0]    target;
    logic [CNT_W:0]    accepted_bits;
    logic [CNT_W:0]    next_accepted;
    logic              handshake;
    logic              restart;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_diff;
    logic              s2_valid;
    logic [POP_W-1:0]  s2_pop;
    logic [POP_W-1:0]  pop;

    logic [CNT_W:0]    bit_sum;
    logic [CNT_W:0]    err_sum;
    logic              word_clamp;

    assign handshake     = s_valid && s_ready;
    assign restart       = start && (state == IDLE || state == DONE);
    assign next_accepted = accepted_bits + WORD_BITS;

    // Control FSM; s_ready/busy/done are registered alongside the state.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= IDLE;
            s_ready       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            drain_cnt     <= '0;
            target        <= '0;
            accepted_bits <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        target        <= {1'b0, target_bits};
                        accepted_bits <= '0;
                        drain_cnt     <= '0;
                        if (target_bits == '0) begin
                            state   <= DONE;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state   <= RUN;
                            s_ready <= 1'b1;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (handshake) begin
                        accepted_bits <= next_accepted;
                        if (next_accepted >= target) begin
                            state     <= DRAIN;
                            s_ready   <= 1'b0;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'(BER_DRAIN_CYCLES - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    ber_popcount #(.DATA_W(DATA_W)) u_popcount (
        .data  (s1_diff),
        .count (pop)
    );

    // S1: difference word, S2: its popcount; reset drops anything in flight.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
            s2_valid <= 1'b0;
            s2_pop   <= '0;
        end else begin
            s1_valid <= handshake;
            s1_diff  <= s_tx_data ^ s_rx_data;
            s2_valid <= s1_valid;
            s2_pop   <= pop;
        end
    end

    // One extra bit on each sum exposes the carry used for clamping.
    assign bit_sum = {1'b0, bit_count} + WORD_BITS;
    assign err_sum = {1'b0, err_count} + (CNT_W+1)'(s2_pop);

    // S3: saturating accumulation; overflow is sticky until restart or reset.
    always_ff @(posedge ACLK) begin
        if (ARESET || restart) begin
            bit_count <= '0;
            err_count <= '0;
            overflow  <= 1'b0;
        end else if (s2_valid) begin
            bit_count <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
            err_count <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
            if (bit_sum[CNT_W] || err_sum[CNT_W] || word_clamp) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef BER_ACC_WORD_ERR_EN
    logic [CNT_W:0] word_sum;

    assign word_sum   = {1'b0, word_err_count} + (CNT_W+1)'(s2_pop != '0);
    assign word_clamp = word_sum[CNT_W];

    always_ff @(posedge ACLK) begin
        if (ARESET || restart) begin
            word_err_count <= '0;
        end else if (s2_valid) begin
            word_err_count <= word_sum[CNT_W] ? '1 : word_sum[CNT_W-1:0];
        end
    end
`else
    assign word_clamp = 1'b0;
`endif

endmodule
